// File: rtl/btn_ctrl.sv
// btn_ctrl: two-button synchronizer, debounce, press/release/long-press events and event counter.
// Optional macro BTN_AUTOREPEAT_EN adds periodic press events while a button is long-pressed.
module btn_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned HOLD_CYCLES     = 27000000,
  parameter int unsigned REPEAT_CYCLES   = 5400000
) (
  input  logic       clk27,
  input  logic       reset,
  input  logic [1:0] btn_n_i,
  output logic [1:0] btn_o,
  output logic [1:0] btn_press_o,
  output logic [1:0] btn_release_o,
  output logic [1:0] btn_long_o,
  output logic [7:0] btn_evt_cnt_o
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW  = $clog2(HOLD_CYCLES + 1);
  localparam logic [DBW-1:0] DB_MAX   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(HOLD_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0]  REP_MAX  = RW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_e;

  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     btn_q, btn_d;
  logic [1:0]     rise, fall;
  logic [1:0]     press_d, press_q, release_q, long_q;
  logic [DBW-1:0] db_cnt_q [2];
  logic [DBW-1:0] db_cnt_d [2];
  logic [HW-1:0]  hold_q   [2];
  state_e         state_q  [2];
  logic [7:0]     evt_cnt_q;
`ifdef BTN_AUTOREPEAT_EN
  logic [RW-1:0]  rep_q    [2];
`else
  if (REPEAT_CYCLES > 0) begin : g_no_repeat
  end
`endif

  // Inverted at the input so a cleared synchronizer reads as "not pressed".
  always_ff @(posedge clk27) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      btn_d[i]    = btn_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != btn_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          btn_d[i] = ~btn_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
        end
      end
    end
    rise = btn_d & ~btn_q;
    fall = ~btn_d & btn_q;
  end

  always_ff @(posedge clk27) begin
    if (reset) begin
      btn_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      btn_q <= btn_d;
      for (int unsigned i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // Press events are decoded ahead of the FSM so the counter can add them in the same edge.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      press_d[i] = rise[i];
`ifdef BTN_AUTOREPEAT_EN
      if (!fall[i]) begin
        if (state_q[i] == ST_PRESSED && hold_q[i] == HOLD_MAX) begin
          press_d[i] = 1'b1;
        end
        if (state_q[i] == ST_HELD && rep_q[i] == REP_MAX) begin
          press_d[i] = 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk27) begin
    if (reset) begin
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      evt_cnt_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i] <= ST_IDLE;
        hold_q[i]  <= '0;
`ifdef BTN_AUTOREPEAT_EN
        rep_q[i]   <= '0;
`endif
      end
    end else begin
      press_q   <= press_d;
      release_q <= fall;
      evt_cnt_q <= evt_cnt_q + 8'(press_d[0]) + 8'(press_d[1]);
      for (int unsigned i = 0; i < 2; i++) begin
        case (state_q[i])
          ST_IDLE: begin
            if (rise[i]) begin
              state_q[i] <= ST_PRESSED;
              hold_q[i]  <= '0;
            end
          end
          ST_PRESSED: begin
            if (fall[i]) begin
              state_q[i] <= ST_IDLE;
            end else if (hold_q[i] == HOLD_MAX) begin
              state_q[i] <= ST_HELD;
              long_q[i]  <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              rep_q[i]   <= '0;
`endif
            end else begin
              hold_q[i] <= hold_q[i] + HW'(1);
            end
          end
          ST_HELD: begin
            // Hold counter is left at its terminal value here, so it never wraps.
            if (fall[i]) begin
              state_q[i] <= ST_IDLE;
              long_q[i]  <= 1'b0;
            end
`ifdef BTN_AUTOREPEAT_EN
            else if (rep_q[i] == REP_MAX) begin
              rep_q[i] <= '0;
            end else begin
              rep_q[i] <= rep_q[i] + RW'(1);
            end
`endif
          end
          default: begin
            state_q[i] <= ST_IDLE;
            long_q[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign btn_o         = btn_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;
  assign btn_long_o    = long_q;
  assign btn_evt_cnt_o = evt_cnt_q;

endmodule

// File: tb/tb_btn_ctrl.sv
// Bench for btn_ctrl: directed scenarios plus random button activity against a timing-rule model.
module tb_btn_ctrl;
  localparam int D    = 4;
  localparam int H    = 20;
  localparam int R    = 5;
  localparam int MAXC = 20000;

  logic       clk27 = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn_n_i = 2'b11;
  logic [1:0] btn_o, btn_press_o, btn_release_o, btn_long_o;
  logic [7:0] btn_evt_cnt_o;

  btn_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk27        (clk27),
    .reset        (reset),
    .btn_n_i      (btn_n_i),
    .btn_o        (btn_o),
    .btn_press_o  (btn_press_o),
    .btn_release_o(btn_release_o),
    .btn_long_o   (btn_long_o),
    .btn_evt_cnt_o(btn_evt_cnt_o)
  );

  always #5 clk27 = ~clk27;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Pressed level present at each clock edge, per button.
  bit         hist [2][MAXC];
  bit         m_out [2];
  int         m_tp  [2];
  logic [1:0] e_out, e_press, e_rel, e_long;
  logic [7:0] e_cnt = 8'h00;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model: the level changes once the last D synchronizer samples all disagree with it;
  // long-press and repeat events follow from elapsed time since the press.
  task automatic model(input bit rst, input logic [1:0] p);
    for (int b = 0; b < 2; b++) begin
      bit tog;
      if (rst) begin
        hist[b][cyc] = 1'b0;
        if (cyc > 0) hist[b][cyc-1] = 1'b0;
        m_out[b] = 1'b0;
        e_press[b] = 1'b0;
        e_rel[b] = 1'b0;
        e_long[b] = 1'b0;
      end else begin
        hist[b][cyc] = p[b];
        e_press[b] = 1'b0;
        e_rel[b] = 1'b0;
        tog = (cyc >= D + 2);
        for (int j = cyc - 1 - D; j <= cyc - 2; j++) begin
          if (tog && hist[b][j] == m_out[b]) tog = 1'b0;
        end
        if (tog) begin
          m_out[b] = !m_out[b];
          if (m_out[b]) begin
            m_tp[b] = cyc;
            e_press[b] = 1'b1;
          end else begin
            e_rel[b] = 1'b1;
          end
        end else if (m_out[b]) begin
`ifdef BTN_AUTOREPEAT_EN
          if (cyc - m_tp[b] >= H && (cyc - m_tp[b] - H) % R == 0) e_press[b] = 1'b1;
`endif
        end
        e_long[b] = m_out[b] && (cyc - m_tp[b] >= H);
      end
      e_out[b] = m_out[b];
    end
    if (rst) e_cnt = 8'h00;
    else e_cnt = e_cnt + 8'(e_press[0]) + 8'(e_press[1]);
  endtask

  task automatic tick();
    @(posedge clk27);
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget observed=%0d expected<%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    model(reset, ~btn_n_i);
    #1;
    check("btn_o", 8'(btn_o), 8'(e_out));
    check("btn_press_o", 8'(btn_press_o), 8'(e_press));
    check("btn_release_o", 8'(btn_release_o), 8'(e_rel));
    check("btn_long_o", 8'(btn_long_o), 8'(e_long));
    check("btn_evt_cnt_o", btn_evt_cnt_o, e_cnt);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int  n, tp, tl, np, exp_np, rel_long;
    bit  found;

    // Reset state
    reset = 1'b1;
    ticks(3);
    check("reset_outputs", 8'({btn_o, btn_press_o, btn_release_o, btn_long_o}), 8'h00);
    check("reset_cnt", btn_evt_cnt_o, 8'h00);
    reset = 1'b0;
    ticks(5);

    // Single press on button 0: 6-cycle latency, single pulse, count 1
    btn_n_i[0] = 1'b0;
    n = 0; found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (btn_press_o[0]) begin found = 1; n = i; end
    end
    check("press_latency", 8'(n), 8'd6);
    check("press_cnt", btn_evt_cnt_o, 8'd1);
    tick();
    check("press_single_pulse", 8'(btn_press_o), 8'b00);
    btn_n_i[0] = 1'b1;
    ticks(10);

    // Short glitch on button 1 is rejected
    btn_n_i[1] = 1'b0;
    ticks(3);
    btn_n_i[1] = 1'b1;
    ticks(10);
    check("glitch_level", 8'(btn_o), 8'b00);
    check("glitch_cnt", btn_evt_cnt_o, 8'd1);

    // Long press on button 0 for 40 cycles
    btn_n_i[0] = 1'b0;
    tp = -1; tl = -1; np = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (btn_press_o[0]) begin
        if (tp < 0) tp = cyc;
        np++;
      end
      if (btn_long_o[0] && tl < 0) tl = cyc;
    end
    check("long_delay", 8'(tl - tp), 8'd20);
    exp_np = 1;
`ifdef BTN_AUTOREPEAT_EN
    exp_np = 4;
`endif
    check("long_press_pulses", 8'(np), 8'(exp_np));
    btn_n_i[0] = 1'b1;
    n = 0; found = 0; rel_long = 1;
    for (int i = 1; i <= 12 && !found; i++) begin
      tick();
      if (btn_release_o[0]) begin found = 1; n = i; rel_long = int'(btn_long_o[0]); end
    end
    check("release_latency", 8'(n), 8'd6);
    check("release_long_clear", 8'(rel_long), 8'd0);
    ticks(10);

    // Reset while long-pressed, button held across reset
    btn_n_i[0] = 1'b0;
    ticks(30);
    check("held_long", 8'(btn_long_o[0]), 8'd1);
    reset = 1'b1;
    tick();
    check("abort_outputs", 8'({btn_o, btn_press_o, btn_release_o, btn_long_o}), 8'h00);
    check("abort_cnt", btn_evt_cnt_o, 8'h00);
    ticks(2);
    reset = 1'b0;
    n = 0; found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (btn_press_o[0]) begin found = 1; n = i; end
    end
    check("post_reset_press_latency", 8'(n), 8'd6);
    btn_n_i[0] = 1'b1;
    ticks(10);

    // Drive the counter to 8'hFF, then press both buttons together
    for (int i = 0; i < 300 && e_cnt != 8'hFF; i++) begin
      btn_n_i[0] = 1'b0;
      ticks(8);
      btn_n_i[0] = 1'b1;
      ticks(8);
    end
    check("cnt_at_ff", btn_evt_cnt_o, 8'hFF);
    btn_n_i = 2'b00;
    found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (btn_press_o != 2'b00) found = 1;
    end
    check("dual_press", 8'(btn_press_o), 8'b11);
    check("cnt_wrap", btn_evt_cnt_o, 8'h01);
    btn_n_i = 2'b11;
    ticks(10);

    // Random activity on both buttons with occasional resets
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 30) == 0) begin
        reset = 1'b1;
        ticks(int'($urandom_range(1, 3)));
        reset = 1'b0;
      end
      btn_n_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ticks(int'($urandom_range(20, 40)));
      else ticks(int'($urandom_range(1, 9)));
    end
    btn_n_i = 2'b11;
    ticks(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/btn_ctrl.md
BTN_CTRL -- requirements
Module: btn_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 270000, stable-input time required before the debounced level changes (10 ms at 27 MHz).
REQ-002 Parameter HOLD_CYCLES, default 27000000, debounced-pressed time before long-press is flagged (1 s).
REQ-003 Parameter REPEAT_CYCLES, default 5400000, auto-repeat period while long-pressed (200 ms).
REQ-004 clk27  input  1  sole clock; free-running 27 MHz system clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_n_i  input  2  raw front-panel buttons, asynchronous, active-low.
REQ-007 btn_o  output  2  debounced button level, active-high (1 = pressed).
REQ-008 btn_press_o  output  2  one-cycle press event pulse per button.
REQ-009 btn_release_o  output  2  one-cycle release event pulse per button.
REQ-010 btn_long_o  output  2  level, high while button held >= HOLD_CYCLES.
REQ-011 btn_evt_cnt_o  output  8  running count of press events, read by the CPU via the controls word.

Function
REQ-012 Each btn_n_i bit SHALL pass through a 2-FF synchronizer in clk27 and be inverted to active-high before any other logic.
REQ-013 Each button SHALL have an independent debounce counter, sized ceil(log2(DEBOUNCE_CYCLES+1)) bits, cleared whenever the synchronized level equals btn_o.
REQ-014 While the synchronized level differs from btn_o, the counter SHALL increment; on reaching DEBOUNCE_CYCLES-1 with the level still differing, btn_o SHALL toggle on the next edge and the counter SHALL clear.
REQ-015 Latency from a clean raw edge to btn_o change SHALL be exactly 2 + DEBOUNCE_CYCLES clk27 cycles.
REQ-016 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change btn_o or produce any event.
REQ-017 Each button SHALL run an FSM with states IDLE, PRESSED, HELD: IDLE->PRESSED on btn_o rise; PRESSED->HELD when the hold counter reaches HOLD_CYCLES-1; PRESSED/HELD->IDLE on btn_o fall.
REQ-018 btn_press_o SHALL pulse high in the same cycle btn_o first reads 1; btn_release_o SHALL pulse high in the same cycle btn_o first reads 0.
REQ-019 btn_long_o SHALL be high exactly while the FSM is in HELD.
REQ-020 The hold counter SHALL clear on IDLE->PRESSED and saturate in HELD (no wrap).
REQ-021 btn_evt_cnt_o SHALL increment by the number of btn_press_o bits high in a cycle (0, 1 or 2), wrapping modulo 256.
REQ-022 Both buttons SHALL be processed fully independently; simultaneous events on both bits SHALL both be reported in the same cycle.

Reset
REQ-023 On reset: synchronizers, debounce and hold/repeat counters cleared; FSMs to IDLE; btn_o, btn_press_o, btn_release_o, btn_long_o = 2'b00; btn_evt_cnt_o = 8'h00.
REQ-024 Reset asserted mid-debounce or in HELD SHALL abort the operation with no pulse emitted; a button physically held across reset deassertion SHALL produce a normal press after 2 + DEBOUNCE_CYCLES cycles.

Configuration
REQ-025 Macro BTN_AUTOREPEAT_EN defined: on entry to HELD and every REPEAT_CYCLES cycles thereafter while in HELD, btn_press_o SHALL pulse (and btn_evt_cnt_o increment); repeat counter clears on HELD entry.
REQ-026 Macro BTN_AUTOREPEAT_EN undefined: no repeat counter synthesized; exactly one btn_press_o pulse per physical press.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5)
REQ-027 btn_n_i[0] 1->0 held -> btn_o[0]=1 and btn_press_o[0] single pulse exactly 6 cycles later; btn_evt_cnt_o=1.
REQ-028 btn_n_i[1] low for 3 cycles then high -> btn_o, pulses, btn_evt_cnt_o unchanged.
REQ-029 btn_n_i[0] held low 40 cycles -> btn_long_o[0] rises 20 cycles after btn_o[0]; with BTN_AUTOREPEAT_EN extra press pulses at HELD entry and every 5 cycles, none without it; release -> btn_release_o[0] pulse and btn_long_o[0]=0 in same cycle.
REQ-030 Both bits fall in the same cycle -> btn_press_o=2'b11 in one cycle, btn_evt_cnt_o advances by 2; start from 8'hFF -> wraps to 8'h01.
REQ-031 Assert reset while btn_long_o[0]=1 with button held -> all outputs 0 next cycle; after release of reset, btn_press_o[0] pulse 6 cycles later.
